// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative shift-add multiply.
// Single-cycle ops land in HOLD one edge after accept; MUL spends WIDTH cycles in MUL_BUSY.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpXor  = 4'd2;
  localparam logic [3:0] OpSlt  = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpNand = 4'd5;
  localparam logic [3:0] OpNor  = 4'd6;
  localparam logic [3:0] OpOr   = 4'd7;
  localparam logic [3:0] OpMul  = 4'd8;

  typedef enum logic [1:0] {StIdle, StMulBusy, StHold} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q;
  logic                 carry_q;
  logic                 ovf_q;

  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_sum;
  logic                 ovf_sub;
  logic                 slt_bit;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_step;
  logic                 accept;

  assign in_ready  = (state_q == StIdle) | ((state_q == StHold) & out_ready);
  assign out_valid = (state_q == StHold);
  assign accept    = in_valid & in_ready;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carryout  = carry_q;
  assign overflow  = ovf_q;

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_sub = (a[Msb] != b[Msb]) & (sub_sum[Msb] != a[Msb]);
  assign slt_bit = sub_sum[Msb] ^ ovf_sub;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (control)
      OpAdd: begin
        {alu_c, alu_res} = add_sum;
        alu_v = (a[Msb] == b[Msb]) & (add_sum[Msb] != a[Msb]);
      end
      OpSub: begin
        {alu_c, alu_res} = sub_sum;
        alu_v = ovf_sub;
      end
      OpXor:  alu_res = a ^ b;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OpAnd:  alu_res = a & b;
      OpNand: alu_res = ~(a & b);
      OpNor:  alu_res = ~(a | b);
      OpOr:   alu_res = a | b;
      default: ;
    endcase
  end

  // Upper half accumulates; lower half starts as the multiplier and shifts out LSB-first.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      if (control == OpMul) begin
        state_q <= StMulBusy;
        cnt_q   <= '0;
        prod_q  <= {{WIDTH{1'b0}}, b};
        mcand_q <= a;
      end else begin
        state_q  <= StHold;
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        carry_q  <= alu_c;
        ovf_q    <= alu_v;
      end
    end else begin
      case (state_q)
        StMulBusy: begin
          prod_q <= prod_step;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q  <= StHold;
            result_q <= prod_step[WIDTH-1:0];
            zero_q   <= (prod_step[WIDTH-1:0] == '0);
            carry_q  <= 1'b0;
            ovf_q    <= |prod_step[2*WIDTH-1:WIDTH];
          end
        end
        StHold: begin
          if (out_ready) state_q <= StIdle;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 32-bit instance for ALU ops, back-pressure and reset,
// and an 8-bit instance for short multiplies.
module tb_alu_pipe;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  control = '0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, zero, carryout, overflow;
  logic [31:0] result;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [3:0]  control8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, zero8, carryout8, overflow8;
  logic [7:0]  result8;

  int tests_run = 0;
  int fails = 0;

  // Packed view: top nibble is {out_valid, carryout, overflow, zero}.
  wire [35:0] obs32 = {out_valid, carryout, overflow, zero, result};
  wire [11:0] obs8  = {out_valid8, carryout8, overflow8, zero8, result8};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .control(control),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .carryout(carryout), .overflow(overflow)
  );

  alu_pipe #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .control(control8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .zero(zero8), .carryout(carryout8), .overflow(overflow8)
  );

  task automatic idle();
    in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1; control = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    in_valid8 = 1'b1; control8 = op; a8 = x; b8 = y;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (obs32 !== 36'h0) begin
      fails++; $display("FAIL reset32: got %h want %h", obs32, 36'h0);
    end
    tests_run++;
    if (obs8 !== 12'h0) begin
      fails++; $display("FAIL reset8: got %h want %h", obs8, 12'h0);
    end
    reset = 1'b0;
    #2;
    tests_run++;
    if ({in_ready, in_ready8} !== 2'b11) begin
      fails++; $display("FAIL reset_ready: got %b want %b", {in_ready, in_ready8}, 2'b11);
    end
  endtask

  task automatic test_add();
    idle();
    issue32(OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    tests_run++;
    if (obs32 !== 36'hA_FFFF_FFFE) begin
      fails++; $display("FAIL add_ovf: got %h want %h", obs32, 36'hA_FFFF_FFFE);
    end
    issue32(OP_ADD, 32'h9000_0000, 32'h8000_0000);
    tests_run++;
    if (obs32 !== 36'hE_1000_0000) begin
      fails++; $display("FAIL add_carry: got %h want %h", obs32, 36'hE_1000_0000);
    end
  endtask

  task automatic test_sub_slt();
    logic [3:0]  ops [4] = '{OP_SUB, OP_SUB, OP_SLT, OP_SLT};
    logic [31:0] xa  [4] = '{32'h1234_5678, 32'h7123_4567, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] xb  [4] = '{32'h1234_5678, 32'hF123_4567, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [35:0] exp [4] = '{36'hD_0000_0000, 36'hA_8000_0000, 36'h8_0000_0001, 36'h9_0000_0000};
    idle();
    for (int i = 0; i < 4; i++) begin
      issue32(ops[i], xa[i], xb[i]);
      tests_run++;
      if (obs32 !== exp[i]) begin
        fails++; $display("FAIL sub_slt[%0d]: got %h want %h", i, obs32, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    idle();
    out_ready = 1'b0;
    issue32(OP_XOR, 32'h8765_4321, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({in_ready, obs32} !== {1'b0, 36'h8_9551_1559}) begin
        fails++;
        $display("FAIL hold[%0d]: got %h want %h", i, {in_ready, obs32}, {1'b0, 36'h8_9551_1559});
      end
      in_valid = 1'b1; control = OP_ADD; a = i; b = 32'h1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b1; control = OP_NOR; a = 32'h0F0F_0F0F; b = 32'h00FF_00FF;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL drain_ready: got %b want %b", in_ready, 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (obs32 !== 36'h8_F000_F000) begin
      fails++; $display("FAIL drain_accept: got %h want %h", obs32, 36'h8_F000_F000);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp [8] = '{36'h8_0000_0016, 36'hC_0000_0002, 36'h8_0000_0006, 36'h9_0000_0000,
                             36'h8_0000_0008, 36'h8_FFFF_FFF7, 36'h8_FFFF_FFF1, 36'h8_0000_000E};
    idle();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; control = 4'(i); a = 32'h0000_000C; b = 32'h0000_000A;
      @(posedge clk); #1;
      tests_run++;
      if (obs32 !== exp[i]) begin
        fails++; $display("FAIL stream[%0d]: got %h want %h", i, obs32, exp[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reserved();
    idle();
    issue32(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tests_run++;
    if (obs32 !== 36'h9_0000_0000) begin
      fails++; $display("FAIL reserved: got %h want %h", obs32, 36'h9_0000_0000);
    end
  endtask

  task automatic test_mul8();
    logic [7:0]  xa  [2] = '{8'h0F, 8'h10};
    logic [7:0]  xb  [2] = '{8'h11, 8'h10};
    logic [11:0] exp [2] = '{12'h8_FF, 12'hB_00};
    int lat;
    bit busy_bad;
    idle();
    for (int i = 0; i < 2; i++) begin
      issue8(OP_MUL, xa[i], xb[i]);
      lat = 0; busy_bad = 1'b0;
      while (!out_valid8 && lat < 20) begin
        if (in_ready8) busy_bad = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
      tests_run++;
      if (lat != 8 || busy_bad) begin
        fails++; $display("FAIL mul8_lat[%0d]: got lat=%0d busy_ready=%0b want lat=8 busy_ready=0",
                          i, lat, busy_bad);
      end
      tests_run++;
      if (obs8 !== exp[i]) begin
        fails++; $display("FAIL mul8[%0d]: got %h want %h", i, obs8, exp[i]);
      end
    end
  endtask

  task automatic test_mul32();
    int lat;
    idle();
    issue32(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat != 32) begin
      fails++; $display("FAIL mul32_lat: got %0d want %0d", lat, 32);
    end
    tests_run++;
    if (obs32 !== 36'hA_FFFF_FFFE) begin
      fails++; $display("FAIL mul32: got %h want %h", obs32, 36'hA_FFFF_FFFE);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit stale;
    idle();
    issue32(OP_MUL, 32'h0000_0003, 32'h0000_0005);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (obs32 !== 36'h0) begin
      fails++; $display("FAIL reset_async: got %h want %h", obs32, 36'h0);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_after: got %b want %b", in_ready, 1'b1);
    end
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    tests_run++;
    if (stale) begin
      fails++; $display("FAIL reset_stale: got out_valid=1 want out_valid=0");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_backpressure();
    test_back_to_back();
    test_reserved();
    test_mul8();
    test_mul32();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
